// File: rtl/iic_master_wr.sv
// Write-only IIC master: START, 7-bit address + W, valid/ready byte stream, STOP.
// Define IIC_MASTER_ACK_CHK_EN to abort straight to STOP on a NACK.
module iic_master_wr #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned SCL_HZ = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] slave_addr,
    input  logic [7:0] byte_data,
    input  logic       byte_last,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    input  logic       sda_in,
    output logic       sda_out,
    output logic       sda_oe
);

    localparam int unsigned QDIV = CLK_HZ / (4 * SCL_HZ);
    localparam int unsigned QW   = (QDIV > 1) ? $clog2(QDIV) : 1;
`ifdef IIC_MASTER_ACK_CHK_EN
    localparam bit ACK_CHK = 1'b1;
`else
    localparam bit ACK_CHK = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          last_q, last_d;
    logic          nack_q, nack_d;
    logic          ack_err_q, ack_err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          scl_q, scl_d;
    logic          sda_out_q, sda_out_d;
    logic          sda_oe_q, sda_oe_d;
    logic          byte_ready_q, byte_ready_d;

    logic q_end, sym_end, data_scl, more_bytes;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            qcnt_q       <= '0;
            quarter_q    <= 2'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            last_q       <= 1'b0;
            nack_q       <= 1'b0;
            ack_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            scl_q        <= 1'b1;
            sda_out_q    <= 1'b1;
            sda_oe_q     <= 1'b0;
            byte_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            qcnt_q       <= qcnt_d;
            quarter_q    <= quarter_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            last_q       <= last_d;
            nack_q       <= nack_d;
            ack_err_q    <= ack_err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            scl_q        <= scl_d;
            sda_out_q    <= sda_out_d;
            sda_oe_q     <= sda_oe_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        qcnt_d       = qcnt_q;
        quarter_d    = quarter_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        last_d       = last_q;
        nack_d       = nack_q;
        ack_err_d    = ack_err_q;
        byte_ready_d = 1'b0;
        scl_d        = 1'b1;
        sda_out_d    = 1'b1;
        sda_oe_d     = 1'b0;

        q_end      = (qcnt_q == QW'(QDIV - 1));
        sym_end    = q_end && (quarter_q == 2'd3);
        data_scl   = (quarter_q == 2'd1) || (quarter_q == 2'd2);
        more_bytes = (quarter_q == 2'd3) && !last_q && !(ACK_CHK && nack_q);

        if (state_q != S_IDLE) begin
            if (q_end) begin
                qcnt_d    = '0;
                quarter_d = 2'(quarter_q + 2'd1);
            end else begin
                qcnt_d = QW'(qcnt_q + QW'(1));
            end
        end

        case (state_q)
            S_IDLE: begin
                qcnt_d    = '0;
                quarter_d = 2'd0;
                if (start) begin
                    state_d   = S_START;
                    shift_d   = {slave_addr, 1'b0};
                    bit_cnt_d = 3'd0;
                    last_d    = 1'b0;
                    nack_d    = 1'b0;
                    ack_err_d = 1'b0;
                end
            end
            S_START: begin
                if (sym_end) state_d = S_ADDR;
            end
            S_ADDR, S_DATA: begin
                if (sym_end) begin
                    shift_d   = {shift_q[6:0], 1'b0};
                    bit_cnt_d = 3'(bit_cnt_q + 3'd1);
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (state_q == S_ADDR) ? S_ADDR_ACK : S_DATA_ACK;
                        nack_d  = 1'b0;
                    end
                end
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                if ((quarter_q == 2'd1) && q_end) begin
                    nack_d = sda_in;
                    if (sda_in) ack_err_d = 1'b1;
                end
                // Ready is raised one clock early so an unstalled source costs no extra cycle.
                if (more_bytes) begin
                    if (((qcnt_q == QW'(QDIV - 2)) || q_end) && byte_valid && !byte_ready_q)
                        byte_ready_d = 1'b1;
                    if (q_end) begin
                        if (byte_ready_q && byte_valid) begin
                            state_d   = S_DATA;
                            shift_d   = byte_data;
                            last_d    = byte_last;
                            bit_cnt_d = 3'd0;
                        end else begin
                            qcnt_d    = qcnt_q;
                            quarter_d = quarter_q;
                        end
                    end
                end else if (sym_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sym_end) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Pad outputs follow the current quarter, one clock behind the state register.
        case (state_q)
            S_START: begin
                sda_oe_d  = 1'b1;
                sda_out_d = (quarter_q == 2'd0);
                scl_d     = (quarter_q != 2'd3);
            end
            S_ADDR, S_DATA: begin
                sda_oe_d  = 1'b1;
                sda_out_d = shift_q[7];
                scl_d     = data_scl;
            end
            S_ADDR_ACK, S_DATA_ACK: begin
                scl_d = data_scl;
            end
            S_STOP: begin
                sda_oe_d  = 1'b1;
                sda_out_d = quarter_q[1];
                scl_d     = (quarter_q != 2'd0);
            end
            default: ;
        endcase
    end

    assign busy_d = (state_d != S_IDLE);
    assign done_d = (state_q == S_STOP) && (state_d == S_IDLE);

    assign byte_ready = byte_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ack_err    = ack_err_q;
    assign scl        = scl_q;
    assign sda_out    = sda_out_q;
    assign sda_oe     = sda_oe_q;

endmodule

// File: tb/tb_iic_master_wr.sv
// Bench for iic_master_wr: protocol-level IIC slave decoder, byte source, transaction model.
module tb_iic_master_wr;

    localparam int unsigned CLK_HZ     = 1_600_000;
    localparam int unsigned SCL_HZ     = 100_000;
    localparam int unsigned QDIV       = CLK_HZ / (4 * SCL_HZ);
    localparam logic [6:0]  SLAVE_ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] slave_addr;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_valid;
    logic       byte_ready;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl;
    logic       sda_out;
    logic       sda_oe;
    logic       sda_line;
    logic       slave_low = 1'b0;

    assign sda_line = sda_oe ? sda_out : !slave_low;

    iic_master_wr #(.CLK_HZ(CLK_HZ), .SCL_HZ(SCL_HZ)) dut (
        .clk(clk), .rst(rst), .start(start), .slave_addr(slave_addr),
        .byte_data(byte_data), .byte_last(byte_last), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .busy(busy), .done(done), .ack_err(ack_err),
        .scl(scl), .sda_in(sda_line), .sda_out(sda_out), .sda_oe(sda_oe)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    // Byte source state: main fills the table, the source process walks it.
    logic [7:0] src_data [0:15];
    int src_n = 0;
    int src_gen = 0;
    int stall_at = -1;
    int stall_len = 1000;
    int hs_cnt = 0;

    // Monitors / slave decoder state
    int rdy_cnt = 0, done_cnt = 0, sda_edge_cnt = 0, scl_hi_cnt = 0;
    int start_cnt = 0, stop_cnt = 0;
    logic scl_r = 1'b1, sda_r = 1'b1, sda_m = 1'b1;
    logic in_frame = 1'b0, addressed = 1'b0;
    int bitpos = 0;
    logic [7:0] acc = 8'd0;
    logic [7:0] rx [0:15];
    int rx_n = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin : source
        int idx, seen_gen, stall_left;
        bit take;
        idx = 0; seen_gen = 0; stall_left = 0;
        byte_valid = 1'b0; byte_data = 8'd0; byte_last = 1'b0;
        forever begin
            @(negedge clk);
            take = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (take) begin idx++; hs_cnt++; end
            if (src_gen != seen_gen) begin
                seen_gen = src_gen; idx = 0; stall_left = stall_len;
            end
            if (idx == stall_at && stall_left > 0) begin
                byte_valid = 1'b0; stall_left--;
            end else if (idx < src_n) begin
                byte_valid = 1'b1; byte_data = src_data[idx]; byte_last = (idx == src_n - 1);
            end else begin
                byte_valid = 1'b0;
            end
        end
    end

    // Slave receiver: START/STOP detection, bits on SCL rise, ACKs only its own address.
    always @(negedge clk) begin
        scl_r <= scl;
        sda_r <= sda_line;
        if (scl && scl_r && sda_r && !sda_line) begin
            start_cnt <= start_cnt + 1; in_frame <= 1'b1; bitpos <= 0; rx_n <= 0; slave_low <= 1'b0;
        end else if (scl && scl_r && !sda_r && sda_line) begin
            stop_cnt <= stop_cnt + 1; in_frame <= 1'b0; slave_low <= 1'b0;
        end else if (in_frame && scl && !scl_r) begin
            if (bitpos < 8) begin
                acc <= {acc[6:0], sda_line}; bitpos <= bitpos + 1;
            end else begin
                bitpos <= 0;
            end
        end else if (in_frame && !scl && scl_r) begin
            if (bitpos == 8) begin
                if (rx_n < 16) rx[rx_n] <= acc;
                rx_n <= rx_n + 1;
                if (rx_n == 0) begin
                    addressed <= (acc[7:1] == SLAVE_ADDR);
                    slave_low <= (acc[7:1] == SLAVE_ADDR);
                end else begin
                    slave_low <= addressed;
                end
            end else begin
                slave_low <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        sda_m <= sda_line;
        if (sda_line !== sda_m) sda_edge_cnt <= sda_edge_cnt + 1;
        if (scl) scl_hi_cnt <= scl_hi_cnt + 1;
        if (byte_ready) rdy_cnt <= rdy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic run_txn(input string tag, input logic [6:0] addr, input int n,
                           input int stall_at_i, input bit mid);
        int hs0, rdy0, done0, st0, sp0, ncyc, fall_n, mark, edge0, hi0, rdys;
        int exp_bytes, exp_cyc;
        bit got, nack, abort;
        src_n = n; stall_at = stall_at_i; stall_len = 1000; src_gen++;
        repeat (3) @(posedge clk);
        #1;
        hs0 = hs_cnt; rdy0 = rdy_cnt; done0 = done_cnt; st0 = start_cnt; sp0 = stop_cnt;
        start = 1'b1; slave_addr = addr;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "/busy_on"}, 32'(busy), 32'd1);
        nack = (addr != SLAVE_ADDR);
`ifdef IIC_MASTER_ACK_CHK_EN
        abort = nack;
`else
        abort = 1'b0;
`endif
        exp_bytes = abort ? 0 : n;
        exp_cyc = (2 + 9 + 9 * exp_bytes) * 4 * int'(QDIV);
        ncyc = 0; fall_n = 0; got = 1'b0; mark = 0; edge0 = 0; hi0 = 0; rdys = 0;
        while (ncyc < 20000) begin
            @(posedge clk); #1;
            ncyc++;
            if (fall_n == 0 && sda_oe && !sda_out) fall_n = ncyc;
            if (mid && ncyc == 300) begin start = 1'b1; slave_addr = 7'h7F; end
            if (mid && ncyc == 301) start = 1'b0;
            if (stall_at_i > 0 && mark == 0 && (hs_cnt - hs0) == stall_at_i) mark = ncyc;
            if (mark > 0 && ncyc == mark + 200) begin
                edge0 = sda_edge_cnt; hi0 = scl_hi_cnt; rdys = rdy_cnt;
            end
            if (mark > 0 && ncyc == mark + 900) begin
                chk({tag, "/stall_scl_now"}, 32'(scl), 32'd0);
                chk({tag, "/stall_scl_high_cycles"}, 32'(scl_hi_cnt - hi0), 32'd0);
                chk({tag, "/stall_sda_edges"}, 32'(sda_edge_cnt - edge0), 32'd0);
                chk({tag, "/stall_ready"}, 32'(rdy_cnt - rdys), 32'd0);
            end
            if (done) begin got = 1'b1; break; end
        end
        chk({tag, "/done_seen"}, 32'(got), 32'd1);
        chk({tag, "/sda_fall_lat"}, 32'(fall_n), 32'(QDIV + 1));
        if (stall_at_i <= 0) chk({tag, "/cycles"}, 32'(ncyc), 32'(exp_cyc));
        chk({tag, "/busy_off"}, 32'(busy), 32'd0);
        chk({tag, "/ack_err"}, 32'(ack_err), 32'(nack));
        @(posedge clk); #1;
        chk({tag, "/done_width"}, 32'(done), 32'd0);
        chk({tag, "/sda_released"}, 32'(sda_oe), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk({tag, "/done_pulses"}, 32'(done_cnt - done0), 32'd1);
        chk({tag, "/handshakes"}, 32'(hs_cnt - hs0), 32'(exp_bytes));
        chk({tag, "/ready_pulses"}, 32'(rdy_cnt - rdy0), 32'(exp_bytes));
        chk({tag, "/starts"}, 32'(start_cnt - st0), 32'd1);
        chk({tag, "/stops"}, 32'(stop_cnt - sp0), 32'd1);
        chk({tag, "/rx_count"}, 32'(rx_n), 32'(exp_bytes + 1));
        chk({tag, "/rx_addr"}, 32'(rx[0]), 32'({addr, 1'b0}));
        for (int i = 1; i <= exp_bytes && i < 16; i++)
            chk($sformatf("%s/rx_byte%0d", tag, i - 1), 32'(rx[i]), 32'(src_data[i - 1]));
    endtask

    initial begin : main
        int hs0, w;
        logic [6:0] ra;
        rst = 1'b1; start = 1'b0; slave_addr = 7'd0;
        repeat (5) @(posedge clk);
        #1;
        chk("reset/scl", 32'(scl), 32'd1);
        chk("reset/sda_out", 32'(sda_out), 32'd1);
        chk("reset/sda_oe", 32'(sda_oe), 32'd0);
        chk("reset/busy", 32'(busy), 32'd0);
        chk("reset/done", 32'(done), 32'd0);
        chk("reset/ack_err", 32'(ack_err), 32'd0);
        chk("reset/byte_ready", 32'(byte_ready), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        src_data[0] = 8'hA5; src_data[1] = 8'h3C;
        run_txn("two_bytes", 7'h50, 2, -1, 1'b0);

        for (int i = 0; i < 8; i++) src_data[i] = 8'(i);
        run_txn("eight_bytes", 7'h50, 8, -1, 1'b0);

        for (int i = 0; i < 3; i++) src_data[i] = 8'($urandom);
        run_txn("stall", 7'h50, 3, 1, 1'b0);

        for (int i = 0; i < 2; i++) src_data[i] = 8'($urandom);
        run_txn("nack_addr", 7'h51, 2, -1, 1'b0);

        for (int i = 0; i < 2; i++) src_data[i] = 8'($urandom);
        run_txn("start_while_busy", 7'h50, 2, -1, 1'b1);

        // Reset in the middle of the first DATA byte
        for (int i = 0; i < 2; i++) src_data[i] = 8'($urandom);
        src_n = 2; stall_at = -1; src_gen++;
        repeat (3) @(posedge clk);
        #1;
        hs0 = hs_cnt;
        start = 1'b1; slave_addr = 7'h50;
        @(posedge clk); #1;
        start = 1'b0;
        w = 0;
        while ((hs_cnt - hs0) < 1 && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        chk("midrst/reached_data", 32'((hs_cnt - hs0) >= 1), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst/scl", 32'(scl), 32'd1);
        chk("midrst/sda_oe", 32'(sda_oe), 32'd0);
        chk("midrst/busy", 32'(busy), 32'd0);
        chk("midrst/byte_ready", 32'(byte_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) src_data[i] = 8'($urandom);
        run_txn("after_reset", 7'h50, 2, -1, 1'b0);

        for (int t = 0; t < 3; t++) begin
            ra = ($urandom_range(0, 2) != 0) ? 7'h50 : 7'($urandom);
            w = int'($urandom_range(1, 4));
            for (int i = 0; i < w; i++) src_data[i] = 8'($urandom);
            run_txn($sformatf("rand%0d", t), ra, w, -1, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
